// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, error-flag positions, receiver FSM states
// and the CRC-4 helpers used to build and check frames.
package alu_pkg;

  typedef enum logic [2:0] {
    and_op = 3'b000,
    or_op  = 3'b001,
    add_op = 3'b100,
    sub_op = 3'b101
  } operation_t;

  localparam int ERR_FRAME_BIT = 2;
  localparam int ERR_CRC_BIT   = 1;
  localparam int ERR_OP_BIT    = 0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_TYPE,
    RX_PAYLOAD,
    RX_STOP
  } state_rx_t;

  // x^4 + x + 1, with the implicit x^4 term left out
  localparam logic [3:0] CRC4_POLY = 4'b0011;

  // One MSB-first step of the CRC-4 LFSR
  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic din);
    logic fb;
    fb = crc[3] ^ din;
    return {crc[2:0], 1'b0} ^ ({4{fb}} & CRC4_POLY);
  endfunction

  // CRC-4 over {B, A, 1'b1, op} for operands of data_w bits (data_w <= 64)
  function automatic logic [3:0] calc_CRC_input(input logic [63:0] b, input logic [63:0] a,
                                                input logic [2:0] op, input int data_w);
    logic [3:0] crc;
    crc = 4'h0;
    for (int i = 63; i >= 0; i--)
      if (i < data_w) crc = crc4_step(crc, b[i]);
    for (int i = 63; i >= 0; i--)
      if (i < data_w) crc = crc4_step(crc, a[i]);
    crc = crc4_step(crc, 1'b1);
    for (int i = 2; i >= 0; i--)
      crc = crc4_step(crc, op[i]);
    return crc;
  endfunction

endpackage

// File: rtl/alu_crc4_serial.sv
// Bit-serial CRC-4 LFSR: one bit per clock while enabled, clear wins over enable.
module alu_crc4_serial
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [3:0] crc
);

  logic fb;
  assign fb = crc[3] ^ din;

  // Shift the remainder left and fold in the polynomial when the feedback bit is set
  always_ff @(posedge clk) begin
    if (rst || clr)
      crc <= 4'h0;
    else if (en)
      crc <= {crc[2:0], 1'b0} ^ ({4{fb}} & CRC4_POLY);
  end

endmodule

// File: rtl/alu_frame_rx.sv
// Serial ALU frame receiver: collects data words into {B, A}, decodes the
// closing ctl word, checks framing / CRC / op and presents a held result.
module alu_frame_rx
  import alu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NWORDS = 2 * DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_a,
  output logic [2:0]        out_op,
  output logic [2:0]        out_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(NWORDS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NWORDS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NWORDS + 1);

  state_rx_t             state, state_next;
  logic [2:0]            bit_cnt;
  logic                  is_ctl;
  logic [2*DATA_W-1:0]   shreg;
  logic [CNT_W-1:0]      word_cnt;
  logic                  frame_err;
  logic [2:0]            op_rx;
  logic [3:0]            crc_rx;
  logic [3:0]            crc_val;
  logic                  crc_en;
  logic                  crc_din;
  logic                  frame_done;
  logic                  frame_bad;
  logic                  crc_bad;
  logic                  op_bad;
  logic [2:0]            new_err;

  alu_crc4_serial u_crc (
    .clk (clk),
    .rst (rst),
    .clr (frame_done),
    .en  (crc_en),
    .din (crc_din),
    .crc (crc_val)
  );

  // Word FSM state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= RX_IDLE;
    else
      state <= state_next;
  end

  // Next state, plus CRC feed: data bits as they arrive, then the constant 1 and the op bits of the ctl word
  always_comb begin
    state_next = state;
    crc_en     = 1'b0;
    crc_din    = sin;
    case (state)
      RX_IDLE:    if (!sin) state_next = RX_TYPE;
      RX_TYPE:    state_next = RX_PAYLOAD;
      RX_PAYLOAD: begin
        if (bit_cnt == 3'd7) state_next = RX_STOP;
        if (!is_ctl) begin
          crc_en = 1'b1;
        end else if (bit_cnt < 3'd4) begin
          crc_en = 1'b1;
          if (bit_cnt == 3'd0) crc_din = 1'b1;
        end
      end
      RX_STOP:    state_next = RX_IDLE;
      default:    state_next = RX_IDLE;
    endcase
  end

  assign frame_done = (state == RX_STOP) && is_ctl;

  // Error flags for the frame closing this cycle; lower flags are only meaningful when higher ones are clear
  always_comb begin
    frame_bad = frame_err || !sin || (word_cnt != CNT_FULL);
    crc_bad   = (crc_val != crc_rx);
    op_bad    = !(op_rx inside {and_op, or_op, add_op, sub_op});
    new_err   = 3'b000;
    new_err[ERR_FRAME_BIT] = frame_bad;
    new_err[ERR_CRC_BIT]   = !frame_bad && crc_bad;
    new_err[ERR_OP_BIT]    = !frame_bad && !crc_bad && op_bad;
  end

  // Word and frame datapath: bit counter, operand shifter, ctl fields, word count and framing flag
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 3'd0;
      is_ctl    <= 1'b0;
      shreg     <= '0;
      word_cnt  <= '0;
      frame_err <= 1'b0;
      op_rx     <= 3'd0;
      crc_rx    <= 4'd0;
    end else begin
      case (state)
        RX_TYPE: begin
          is_ctl <= sin;
          if (!sin && word_cnt != CNT_SAT) word_cnt <= word_cnt + 1'b1;
        end
        RX_PAYLOAD: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (!is_ctl)
            shreg <= {shreg[2*DATA_W-2:0], sin};
          else if (bit_cnt >= 3'd4)
            crc_rx <= {crc_rx[2:0], sin};
          else if (bit_cnt != 3'd0)
            op_rx <= {op_rx[1:0], sin};
        end
        RX_STOP: begin
          if (is_ctl) begin
            word_cnt  <= '0;
            frame_err <= 1'b0;
          end else if (!sin) begin
            frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result hand-off: load on completion unless an unaccepted result is pending, which makes the new frame an overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_b     <= '0;
      out_a     <= '0;
      out_op    <= 3'd0;
      out_err   <= 3'd0;
      overrun   <= 1'b0;
    end else if (frame_done) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_b     <= shreg[2*DATA_W-1:DATA_W];
        out_a     <= shreg[DATA_W-1:0];
        out_op    <= op_rx;
        out_err   <= new_err;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_frame_rx.sv
// Directed bench for alu_frame_rx: frames are driven bit-serially, expected
// results are queued as frames are sent and popped when the result appears.
module tb_alu_frame_rx;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic sin32, sin8;
  logic out_ready;

  logic        v32, ovr32;
  logic [31:0] b32, a32;
  logic [2:0]  op32, err32;
  logic        v8, ovr8;
  logic [7:0]  b8, a8;
  logic [2:0]  op8, err8;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] b;
    logic [63:0] a;
    logic [2:0]  op;
    logic [2:0]  err;
    logic        chk_ab;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_frame_rx #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst), .sin(sin32), .out_valid(v32), .out_ready(out_ready),
    .out_b(b32), .out_a(a32), .out_op(op32), .out_err(err32), .overrun(ovr32)
  );

  alu_frame_rx #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .sin(sin8), .out_valid(v8), .out_ready(out_ready),
    .out_b(b8), .out_a(a8), .out_op(op8), .out_err(err8), .overrun(ovr8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic sel8, input logic bv);
    @(negedge clk);
    if (sel8) sin8 = bv;
    else      sin32 = bv;
  endtask

  task automatic send_word(input logic sel8, input logic typ, input logic [7:0] pl,
                           input logic stopb, input logic rdy_at_stop);
    drive_bit(sel8, 1'b0);
    drive_bit(sel8, typ);
    for (int i = 7; i >= 0; i--) drive_bit(sel8, pl[i]);
    drive_bit(sel8, stopb);
    if (rdy_at_stop) out_ready = 1'b1;
  endtask

  task automatic send_frame(input logic sel8, input logic [63:0] b, input logic [63:0] a,
                            input logic [2:0] op, input logic [3:0] crc, input int ndata,
                            input int bad_stop, input logic rdy_at_stop);
    int dw;
    logic [127:0] cat;
    logic [7:0] byte_v;
    dw  = sel8 ? 8 : 32;
    cat = ({64'b0, b} << dw) | {64'b0, a};
    for (int k = 0; k < ndata; k++) begin
      byte_v = 8'(cat >> (2 * dw - 8 * (k + 1)));
      send_word(sel8, 1'b0, byte_v, k != bad_stop, 1'b0);
    end
    send_word(sel8, 1'b1, {1'b0, op, crc}, 1'b1, rdy_at_stop);
  endtask

  task automatic push_exp(input logic [63:0] b, input logic [63:0] a, input logic [2:0] op,
                          input logic [2:0] err, input logic chk_ab);
    exp_t e;
    e.b = b; e.a = a; e.op = op; e.err = err; e.chk_ab = chk_ab;
    sb.push_back(e);
  endtask

  task automatic check_out(input logic sel8, input string tag);
    exp_t e;
    logic v;
    logic [63:0] ob, oa;
    logic [2:0] oop, oerr;
    if (sel8) begin
      v = v8;  ob = {56'b0, b8};  oa = {56'b0, a8};  oop = op8;  oerr = err8;
    end else begin
      v = v32; ob = {32'b0, b32}; oa = {32'b0, a32}; oop = op32; oerr = err32;
    end
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, {63'b0, v}, 64'd1);
      check({tag, "_err"}, {61'b0, oerr}, {61'b0, e.err});
      check({tag, "_op"}, {61'b0, oop}, {61'b0, e.op});
      if (e.chk_ab) begin
        check({tag, "_b"}, ob, e.b);
        check({tag, "_a"}, oa, e.a);
      end
    end
  endtask

  // Stop bit was just driven: no result yet, one clock later the result must be up
  task automatic finish_frame(input logic sel8, input string tag);
    check({tag, "_valid_at_stop"}, {63'b0, sel8 ? v8 : v32}, 64'd0);
    @(negedge clk);
    check_out(sel8, tag);
  endtask

  task automatic accept(input logic sel8, input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_dropped"}, {63'b0, sel8 ? v8 : v32}, 64'd0);
  endtask

  initial begin
    logic [3:0] crc;
    logic seen;
    rst = 1'b1; sin32 = 1'b1; sin8 = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {63'b0, v32}, 64'd0);
    check("rst_b", {32'b0, b32}, 64'd0);
    check("rst_a", {32'b0, a32}, 64'd0);
    check("rst_op_err", {58'b0, op32, err32}, 64'd0);
    check("rst_overrun", {63'b0, ovr32}, 64'd0);
    check("rst_valid8", {63'b0, v8}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Valid add frame
    crc = calc_CRC_input(64'h5, 64'h3, add_op, 32);
    push_exp(64'h5, 64'h3, add_op, 3'b000, 1'b1);
    send_frame(1'b0, 64'h5, 64'h3, add_op, crc, 8, -1, 1'b0);
    finish_frame(1'b0, "good_add");
    accept(1'b0, "good_add");

    // Same frame, CRC LSB flipped
    push_exp(64'h5, 64'h3, add_op, 3'b010, 1'b1);
    send_frame(1'b0, 64'h5, 64'h3, add_op, crc ^ 4'h1, 8, -1, 1'b0);
    finish_frame(1'b0, "bad_crc");
    accept(1'b0, "bad_crc");

    // Only 7 data words: framing error, which also masks the CRC flag
    push_exp(64'h5, 64'h3, add_op, 3'b100, 1'b0);
    send_frame(1'b0, 64'h5, 64'h3, add_op, crc, 7, -1, 1'b0);
    finish_frame(1'b0, "short_frame");
    accept(1'b0, "short_frame");

    // Zero stop bit in a data word: framing error
    push_exp(64'h5, 64'h3, add_op, 3'b100, 1'b0);
    send_frame(1'b0, 64'h5, 64'h3, add_op, crc, 8, 3, 1'b0);
    finish_frame(1'b0, "bad_stop");
    accept(1'b0, "bad_stop");

    // Unknown op with a matching CRC
    crc = calc_CRC_input(64'h12345678, 64'h9abcdef0, 3'b010, 32);
    push_exp(64'h12345678, 64'h9abcdef0, 3'b010, 3'b001, 1'b1);
    send_frame(1'b0, 64'h12345678, 64'h9abcdef0, 3'b010, crc, 8, -1, 1'b0);
    finish_frame(1'b0, "bad_op");
    accept(1'b0, "bad_op");

    // Back-to-back with no consumer: second frame dropped, first held, overrun set
    crc = calc_CRC_input(64'h11, 64'h22, or_op, 32);
    push_exp(64'h11, 64'h22, or_op, 3'b000, 1'b1);
    send_frame(1'b0, 64'h11, 64'h22, or_op, crc, 8, -1, 1'b0);
    crc = calc_CRC_input(64'hAA, 64'hBB, sub_op, 32);
    send_frame(1'b0, 64'hAA, 64'hBB, sub_op, crc, 8, -1, 1'b0);
    @(negedge clk);
    check_out(1'b0, "held");
    check("overrun_set", {63'b0, ovr32}, 64'd1);

    // Completion coinciding with acceptance: new result loads, valid stays high
    crc = calc_CRC_input(64'hCAFE, 64'hF00D, sub_op, 32);
    push_exp(64'hCAFE, 64'hF00D, sub_op, 3'b000, 1'b1);
    send_frame(1'b0, 64'hCAFE, 64'hF00D, sub_op, crc, 8, -1, 1'b1);
    @(negedge clk);
    check_out(1'b0, "coincide");
    check("overrun_sticky", {63'b0, ovr32}, 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
    check("coincide_valid_dropped", {63'b0, v32}, 64'd0);

    // Reset in the middle of the second data word of a frame
    send_word(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; sin32 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen |= v32;
    end
    check("midrst_no_valid", {63'b0, seen}, 64'd0);
    check("midrst_outputs", {b32, a32}, 64'd0);
    check("midrst_op_err", {58'b0, op32, err32}, 64'd0);
    check("midrst_overrun", {63'b0, ovr32}, 64'd0);

    // Recovery after reset: partial frame left no word count behind
    crc = calc_CRC_input(64'h7, 64'h9, and_op, 32);
    push_exp(64'h7, 64'h9, and_op, 3'b000, 1'b1);
    send_frame(1'b0, 64'h7, 64'h9, and_op, crc, 8, -1, 1'b0);
    finish_frame(1'b0, "post_rst");
    accept(1'b0, "post_rst");

    // 8-bit instance, two data words
    crc = calc_CRC_input(64'h80, 64'h01, and_op, 8);
    push_exp(64'h80, 64'h01, and_op, 3'b000, 1'b1);
    send_frame(1'b1, 64'h80, 64'h01, and_op, crc, 2, -1, 1'b0);
    finish_frame(1'b1, "w8_and");
    accept(1'b1, "w8_and");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
